// File: rtl/issue_select_scheduler.sv
// Issue-queue control: owns slot valid bits, picks the lowest free slot for allocation,
// and uses an age matrix to dispatch the oldest operand-ready entry each cycle.
module issue_select_scheduler #(
  parameter int N_ENTRIES = 16,
  parameter int IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 STALL,
  input  logic                 FLUSH,
  input  logic                 alloc_req,
  output logic                 alloc_ready,
  output logic [IDX_W-1:0]     alloc_idx,
  input  logic [N_ENTRIES-1:0] ready_vec,
  output logic                 issue_valid,
  output logic [IDX_W-1:0]     issue_idx,
  output logic [N_ENTRIES-1:0] issue_onehot,
  output logic [IDX_W:0]       occupancy,
  output logic                 full,
  output logic                 empty
);

  localparam logic [IDX_W:0] FULL_CNT = N_ENTRIES[IDX_W:0];

  logic [N_ENTRIES-1:0] valid_q, valid_d;
  logic [N_ENTRIES-1:0] older_q [N_ENTRIES];
  logic [N_ENTRIES-1:0] older_d [N_ENTRIES];
  logic                 issue_valid_q, issue_valid_d;
  logic [IDX_W-1:0]     issue_idx_q, issue_idx_d;
  logic [N_ENTRIES-1:0] issue_onehot_q, issue_onehot_d;
  logic [IDX_W:0]       occupancy_q, occupancy_d;

  logic [N_ENTRIES-1:0] cand;
  logic [N_ENTRIES-1:0] is_oldest;
  logic [IDX_W-1:0]     oldest_idx;
  logic                 do_alloc;
  logic                 do_issue;

  assign full        = (occupancy_q == FULL_CNT);
  assign empty       = (occupancy_q == '0);
  assign alloc_ready = !full && !STALL && !FLUSH;
  assign do_alloc    = alloc_req && alloc_ready;
  assign cand        = valid_q & ready_vec;
  assign do_issue    = !STALL && !FLUSH && (|cand);

  always_comb begin
    alloc_idx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = i[IDX_W-1:0];
    end
  end

  // A candidate is oldest when no other candidate has its bit set in this column.
  generate
    for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_sel
      logic [N_ENTRIES-1:0] col;
      always_comb begin
        col = '0;
        for (int j = 0; j < N_ENTRIES; j++) col[j] = older_q[j][gi];
      end
      assign is_oldest[gi] = cand[gi] && !(|(cand & col));
    end
  endgenerate

  always_comb begin
    oldest_idx = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (is_oldest[i]) oldest_idx = oldest_idx | i[IDX_W-1:0];
    end
  end

  always_comb begin
    valid_d        = valid_q;
    older_d        = older_q;
    issue_valid_d  = 1'b0;
    issue_idx_d    = issue_idx_q;
    issue_onehot_d = '0;
    occupancy_d    = occupancy_q;
    if (FLUSH) begin
      valid_d     = '0;
      occupancy_d = '0;
      for (int i = 0; i < N_ENTRIES; i++) older_d[i] = '0;
    end else if (!STALL) begin
      if (do_alloc) begin
        valid_d[alloc_idx] = 1'b1;
        for (int j = 0; j < N_ENTRIES; j++) older_d[j][alloc_idx] = valid_q[j];
        older_d[alloc_idx] = '0;
      end
      // Clearing the issued row/column after the alloc update also drops any
      // freshly-set older[oldest][new] bit when both happen on one edge.
      if (do_issue) begin
        valid_d[oldest_idx] = 1'b0;
        older_d[oldest_idx] = '0;
        for (int j = 0; j < N_ENTRIES; j++) older_d[j][oldest_idx] = 1'b0;
        issue_valid_d  = 1'b1;
        issue_idx_d    = oldest_idx;
        issue_onehot_d = is_oldest;
      end
      occupancy_d = occupancy_q + {{IDX_W{1'b0}}, do_alloc} - {{IDX_W{1'b0}}, do_issue};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q        <= '0;
      issue_valid_q  <= 1'b0;
      issue_idx_q    <= '0;
      issue_onehot_q <= '0;
      occupancy_q    <= '0;
      for (int i = 0; i < N_ENTRIES; i++) older_q[i] <= '0;
    end else begin
      valid_q        <= valid_d;
      issue_valid_q  <= issue_valid_d;
      issue_idx_q    <= issue_idx_d;
      issue_onehot_q <= issue_onehot_d;
      occupancy_q    <= occupancy_d;
      for (int i = 0; i < N_ENTRIES; i++) older_q[i] <= older_d[i];
    end
  end

  assign issue_valid  = issue_valid_q;
  assign issue_idx    = issue_idx_q;
  assign issue_onehot = issue_onehot_q;
  assign occupancy    = occupancy_q;

endmodule

// File: doc/issue_select_scheduler.md
Name: issue_select_scheduler

Overview:
- Control side of the 16-entry issue queue.
- Owns per-slot valid bits and tells the queue which empty slot receives the next renamed instruction.
- Tracks relative age of resident entries with an age matrix and each cycle selects the oldest operand-ready entry to send to execution.
- Replaces the fixed-priority empty-slot and ready-slot arbiters; the queue datapath indexes its storage with alloc_idx and issue_idx.

Parameters:
N_ENTRIES, 16, number of issue-queue slots.
IDX_W, 4, slot index width, equal to clog2(N_ENTRIES).

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RESET  in  1  asynchronous, active-high reset.
STALL  in  1  pipeline stall; freezes the scheduler.
FLUSH  in  1  synchronous squash of all resident entries.
alloc_req  in  1  rename has an instruction to enqueue this cycle.
alloc_ready  out  1  combinational: a slot can be accepted this cycle.
alloc_idx  out  IDX_W  combinational: lowest-numbered free slot; 0 when full.
ready_vec  in  N_ENTRIES  per-slot "all operands ready" from the queue datapath.
issue_valid  out  1  registered: issue_idx/issue_onehot name an entry dispatched this edge.
issue_idx  out  IDX_W  registered index of the issued slot.
issue_onehot  out  N_ENTRIES  registered one-hot form of issue_idx; all zero when issue_valid is 0.
occupancy  out  IDX_W+1  registered count of valid entries, range 0..N_ENTRIES.
full  out  1  occupancy == N_ENTRIES.
empty  out  1  occupancy == 0.

Behaviour:
- Reset (async, RESET=1): valid=0, age matrix=0, issue_valid=0, issue_idx=0, issue_onehot=0, occupancy=0. Result: full=0, empty=1, alloc_ready=!STALL.
- State consists of valid[N], the age matrix older[i][j] (1 means entry i is older than entry j), the issue output registers and occupancy.
- alloc_ready = !full && !STALL && !FLUSH. Allocation is accepted when alloc_req && alloc_ready at the edge.
- Accepted allocation: valid[alloc_idx]<=1. The new entry becomes youngest: older[j][alloc_idx]<=valid[j] and older[alloc_idx][j]<=0 for all j.
- Candidate set cand = valid & ready_vec. ready_vec bits of invalid slots are ignored.
- Oldest candidate is the unique i in cand with no j in cand where older[j][i]=1. Selection is combinational from current state.
- At an unstalled edge with cand nonzero: issue_valid<=1, issue_idx<=oldest, issue_onehot<=1<<oldest, valid[oldest]<=0, and row and column oldest of the age matrix are cleared.
- At an unstalled edge with cand zero: issue_valid<=0, issue_onehot<=0, issue_idx holds.
- Latency:
  - An allocated entry is first eligible one edge after allocation (its valid was 0 at the allocating edge).
  - A slot freed by issue can first be reallocated on the following edge (alloc_idx is computed from pre-edge valid).
- Same-edge allocate and issue: both take effect; occupancy is unchanged. When full with one issuing, alloc_ready is still 0 that cycle.
- occupancy updates by +1 on alloc only, -1 on issue only, 0 on both.
- STALL=1 (and FLUSH=0): valid, the age matrix and occupancy hold; no allocation or issue occurs; issue_valid<=0 and issue_onehot<=0 so an entry is never dispatched twice.
- FLUSH=1: valid<=0, age matrix<=0, occupancy<=0, issue_valid<=0, issue_onehot<=0. FLUSH overrides STALL, alloc and issue in the same cycle.
- RESET asserted mid-operation clears state immediately, regardless of CLK.
- Invariants, to be asserted in the bench:
  - older is antisymmetric over valid pairs.
  - At most one oldest candidate exists.
  - popcount(valid) == occupancy.

Test Plan:
- Reset, then alloc_req=1 for 16 cycles with ready_vec=0 -> alloc_idx 0,1,...,15 in turn; occupancy=16, full=1, alloc_ready=0, issue_valid stays 0.
- From empty, allocate slots 0,1,2 on consecutive edges, then ready_vec=all ones -> issue_idx 0,1,2 on three successive edges, then issue_valid=0 and empty=1.
- Age beats index: allocate slots 0..3, issue slot 1 (ready_vec=0x0002), reallocate (alloc_idx=1), then ready_vec=0x000F -> issue order 0,2,3,1.
- Full queue, ready_vec=0x0080 with alloc_req=1 -> slot 7 issues, occupancy becomes 15, alloc_ready=0 that cycle; next cycle alloc_idx=7 and allocation is accepted, occupancy back to 16.
- STALL=1 for 3 cycles with ready entries -> issue_valid=0, occupancy and alloc_idx unchanged; on STALL=0 the oldest ready entry issues on the next edge.
- 5 entries resident, FLUSH=1 concurrent with alloc_req=1 and ready entries -> next edge occupancy=0, empty=1, issue_valid=0; async RESET pulse mid-cycle gives the same result immediately.
